// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the display/host SRAM arbiter.
package sram_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 18;
  localparam int unsigned DATA_W_DEF = 16;

  localparam int unsigned BE_UB = 1;
  localparam int unsigned BE_LB = 0;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DRD_A = 3'd1,
    DRD_C = 3'd2,
    HRD_A = 3'd3,
    HRD_C = 3'd4,
    WR_S  = 3'd5,
    WR_P  = 3'd6,
    WR_H  = 3'd7
  } arb_state_t;

endpackage

// File: rtl/sram_arbiter.sv
// Arbitrates a latency-critical display reader and a host read/write port
// onto one asynchronous SRAM; every SRAM pin is driven from a register.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk50M,
  input  logic              n_reset,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_rdata,
  output logic              disp_valid,
  output logic              disp_overrun,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic [1:0]        host_be,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_ack,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic [DATA_W-1:0] sram_dq_in,
  output logic [DATA_W-1:0] sram_dq_out,
  output logic              sram_dq_oe,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              sram_ub_n,
  output logic              sram_lb_n
);

  arb_state_t        r_state;
  logic              r_disp_pend;
  logic [ADDR_W-1:0] r_disp_addr;
  logic              r_overrun;
  logic              r_disp_valid;
  logic [DATA_W-1:0] r_disp_rdata;
  logic              r_host_ack;
  logic [DATA_W-1:0] r_host_rdata;
  logic [ADDR_W-1:0] r_sram_addr;
  logic [DATA_W-1:0] r_dq_out;
  logic              r_dq_oe;
  logic              r_ce_n;
  logic              r_oe_n;
  logic              r_we_n;
  logic              r_ub_n;
  logic              r_lb_n;

  logic              w_arb_pt;
  logic              w_host_ok;
  logic              w_go_disp;
  logic              w_go_hrd;
  logic              w_go_wr;
  logic [ADDR_W-1:0] w_disp_sel;

  // The host request finishing in HRD_C/WR_H is still high until its ack,
  // so the host is only eligible from IDLE or after a display read.
  assign w_arb_pt   = (r_state == IDLE) || (r_state == DRD_C) ||
                      (r_state == HRD_C) || (r_state == WR_H);
  assign w_host_ok  = (r_state == IDLE) || (r_state == DRD_C);
  assign w_go_disp  = w_arb_pt && (r_disp_pend || disp_req);
  assign w_go_hrd   = w_arb_pt && !w_go_disp && w_host_ok && host_req && !host_we;
  assign w_go_wr    = w_arb_pt && !w_go_disp && w_host_ok && host_req && host_we;
  assign w_disp_sel = r_disp_pend ? r_disp_addr : disp_addr;

  always_ff @(posedge clk50M) begin
    if (!n_reset) begin
      r_state      <= IDLE;
      r_disp_pend  <= 1'b0;
      r_disp_addr  <= '0;
      r_overrun    <= 1'b0;
      r_disp_valid <= 1'b0;
      r_disp_rdata <= '0;
      r_host_ack   <= 1'b0;
      r_host_rdata <= '0;
      r_sram_addr  <= '0;
      r_dq_out     <= '0;
      r_dq_oe      <= 1'b0;
      r_ce_n       <= 1'b1;
      r_oe_n       <= 1'b1;
      r_we_n       <= 1'b1;
      r_ub_n       <= 1'b1;
      r_lb_n       <= 1'b1;
    end else begin
      r_disp_valid <= 1'b0;
      r_host_ack   <= 1'b0;

      // Pending display request: consumed on grant, re-armed by a same-cycle request.
      if (w_go_disp) begin
        if (r_disp_pend) begin
          r_disp_pend <= disp_req;
          if (disp_req) r_disp_addr <= disp_addr;
        end
      end else if (disp_req) begin
        if (r_disp_pend) begin
          r_overrun <= 1'b1;
        end else begin
          r_disp_pend <= 1'b1;
          r_disp_addr <= disp_addr;
        end
      end

      case (r_state)
        DRD_C: begin
          r_disp_rdata <= sram_dq_in;
          r_disp_valid <= 1'b1;
        end
        HRD_C: begin
          r_host_rdata <= sram_dq_in;
          r_host_ack   <= 1'b1;
        end
        WR_H:    r_host_ack <= 1'b1;
        default: ;
      endcase

      if (w_go_disp) begin
        r_state     <= DRD_A;
        r_sram_addr <= w_disp_sel;
        r_dq_oe     <= 1'b0;
        r_ce_n      <= 1'b0;
        r_oe_n      <= 1'b0;
        r_we_n      <= 1'b1;
        r_ub_n      <= 1'b0;
        r_lb_n      <= 1'b0;
      end else if (w_go_hrd) begin
        r_state     <= HRD_A;
        r_sram_addr <= host_addr;
        r_dq_oe     <= 1'b0;
        r_ce_n      <= 1'b0;
        r_oe_n      <= 1'b0;
        r_we_n      <= 1'b1;
        r_ub_n      <= 1'b0;
        r_lb_n      <= 1'b0;
      end else if (w_go_wr) begin
        r_state     <= WR_S;
        r_sram_addr <= host_addr;
        r_dq_out    <= host_wdata;
        r_dq_oe     <= 1'b1;
        r_ce_n      <= 1'b0;
        r_oe_n      <= 1'b1;
        r_we_n      <= 1'b1;
        r_ub_n      <= ~host_be[BE_UB];
        r_lb_n      <= ~host_be[BE_LB];
      end else if (w_arb_pt) begin
        r_state <= IDLE;
        r_dq_oe <= 1'b0;
        r_ce_n  <= 1'b1;
        r_oe_n  <= 1'b1;
        r_we_n  <= 1'b1;
        r_ub_n  <= 1'b1;
        r_lb_n  <= 1'b1;
      end else begin
        case (r_state)
          DRD_A: r_state <= DRD_C;
          HRD_A: r_state <= HRD_C;
          WR_S: begin
            r_state <= WR_P;
            r_we_n  <= 1'b0;
          end
          WR_P: begin
            r_state <= WR_H;
            r_we_n  <= 1'b1;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign disp_rdata   = r_disp_rdata;
  assign disp_valid   = r_disp_valid;
  assign disp_overrun = r_overrun;
  assign host_rdata   = r_host_rdata;
  assign host_ack     = r_host_ack;
  assign sram_addr    = r_sram_addr;
  assign sram_dq_out  = r_dq_out;
  assign sram_dq_oe   = r_dq_oe;
  assign sram_ce_n    = r_ce_n;
  assign sram_oe_n    = r_oe_n;
  assign sram_we_n    = r_we_n;
  assign sram_ub_n    = r_ub_n;
  assign sram_lb_n    = r_lb_n;

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 18, SRAM word-address width.
REQ-002 SHALL have parameter DATA_W, default 16, SRAM data width.
REQ-003 SHALL have port clk50M, input, 1, system clock; all logic on its rising edge.
REQ-004 SHALL have port n_reset, input, 1, reset: synchronous, active-low.
REQ-005 SHALL have display port: disp_req in 1 (one-cycle pulse); disp_addr in ADDR_W; disp_rdata out DATA_W; disp_valid out 1 (one-cycle pulse); disp_overrun out 1 (sticky error flag).
REQ-006 SHALL have host port: host_req in 1 (level, held until ack); host_we in 1; host_addr in ADDR_W; host_wdata in DATA_W; host_be in 2 ([1]=upper byte, [0]=lower byte); host_rdata out DATA_W; host_ack out 1 (one-cycle pulse).
REQ-007 SHALL have SRAM port: sram_addr out ADDR_W; sram_dq_in in DATA_W; sram_dq_out out DATA_W; sram_dq_oe out 1; sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n out 1 each.
- Tristate is resolved at the top level.

Function
REQ-008 SHALL drive every SRAM-side output from a register; no combinational path from any input to any SRAM pin.
REQ-009 SHALL capture disp_req into disp_pend, latching disp_addr in the same cycle.
REQ-010 SHALL, on disp_req while disp_pend=1 and not being consumed that cycle, drop the new request and set disp_overrun; disp_overrun clears only on reset.
REQ-011 SHALL implement states IDLE, DRD_A, DRD_C, HRD_A, HRD_C, WR_S, WR_P, WR_H.
REQ-012 SHALL arbitrate in IDLE and on exit from DRD_C, HRD_C and WR_H, using the following priority:
- (disp_pend or disp_req) -> DRD_A;
- else host_req & ~host_we -> HRD_A;
- else host_req & host_we -> WR_S;
- else IDLE.
REQ-013 SHALL, on entering DRD_A, consume disp_pend; a disp_req arriving in that same cycle re-arms disp_pend with its new address and is not an overrun.
REQ-014 SHALL behave as follows in read states (DRD_A/DRD_C, HRD_A/HRD_C):
- sram_ce_n=0, sram_oe_n=0, sram_ub_n=sram_lb_n=0, sram_dq_oe=0, sram_addr = the latched address;
- sram_dq_in is sampled at the end of the *_C state.
REQ-015 SHALL pulse disp_valid, with disp_rdata updated, in the cycle after DRD_C; latency from disp_req in IDLE is 3 cycles.
REQ-016 SHALL pulse host_ack, with host_rdata updated, in the cycle after HRD_C.
REQ-017 SHALL perform writes over three cycles:
- all three cycles: sram_dq_oe=1; sram_dq_out, sram_addr and byte enables (sram_ub_n=~host_be[1], sram_lb_n=~host_be[0]) held constant; sram_oe_n=1;
- WR_S: address/data setup; WR_P: sram_we_n=0; WR_H: sram_we_n=1, data held;
- host_ack pulses in the cycle after WR_H.
REQ-018 SHALL latch host_addr, host_wdata, host_be and host_we at arbitration; later host changes do not affect the transaction in flight.
REQ-019 SHALL bound worst-case display latency at 6 cycles: a write just granted, then DRD_A and DRD_C.
- The display requester guarantees disp_req spacing of at least 4 cycles.
REQ-020 SHALL, with host_be=2'b00 on a write, still run WR_S..WR_H with both byte strobes high, and ack.
REQ-021 SHALL, if host_req is still high in the ack cycle, treat it as a new transaction.
REQ-022 SHALL drive sram_ce_n=1 and sram_oe_n=1 in IDLE.

Reset
REQ-023 SHALL, while n_reset=0 at a clock edge, apply the following (including mid-transaction, with no ack or valid for any aborted access):
- state=IDLE; disp_pend=0; disp_overrun=0; disp_valid=0; host_ack=0;
- sram_dq_oe=0; sram_ce_n=sram_oe_n=sram_we_n=sram_ub_n=sram_lb_n=1;
- sram_addr=0, sram_dq_out=0, disp_rdata=0, host_rdata=0.

Structure
REQ-024 SHALL place the state enumeration, ADDR_W/DATA_W defaults and byte-enable index constants in shared package sram_arb_pkg.
REQ-025 SHALL be a single module without sub-modules.

Verification
REQ-026 SHALL cover the following directed scenarios:
- Display read: disp_req, addr 0x00010, SRAM model word 0xA55A -> disp_valid 3 cycles later, disp_rdata=0xA55A.
- Host write: host_we=1, addr 0x3FFFF, data 0x1234, be=2'b10 -> sram_we_n low exactly 1 cycle, sram_ub_n=0, sram_lb_n=1, ack 4 cycles after grant; model upper byte=0x12, lower byte unchanged.
- Collision: disp_req 1 cycle after a host write is granted -> write completes uncorrupted; disp_valid at most 6 cycles after disp_req; no overrun.
- Overrun: two disp_req 1 cycle apart during a write -> second dropped, disp_overrun=1 sticky, exactly one disp_valid.
- Reset mid-write in WR_P -> next cycle sram_we_n=1, sram_dq_oe=0, state IDLE, no host_ack.
- Sustained load: disp_req every 4 cycles with host_req held -> zero overrun, host read/write acks still occur, SRAM contents match the reference model.
